// File: rtl/sdpram_arbiter.sv
// Round-robin arbiter that shares both ports of the 32 x 256 dual-port RAM among N_REQ requesters.
// Grants up to two requests per cycle, blocks cross-port address hazards and routes read data back.
module sdpram_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 256,
    parameter int ADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_wen,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_d,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [N_REQ*DATA_W-1:0]   rsp_q,
    output logic [ADDR_W-1:0]         addr_a,
    output logic [ADDR_W-1:0]         addr_b,
    output logic [DATA_W-1:0]         d_a,
    output logic [DATA_W-1:0]         d_b,
    output logic                      wen_a,
    output logic                      wen_b,
    input  logic [DATA_W-1:0]         q_a,
    input  logic [DATA_W-1:0]         q_b
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] a_idx;
    logic [PTR_W-1:0] b_idx;
    logic             a_found;
    logic             b_found;

    logic             pend_a_valid;
    logic             pend_b_valid;
    logic [PTR_W-1:0] pend_a_idx;
    logic [PTR_W-1:0] pend_b_idx;

    // Scan from rr_ptr: first valid requester takes port A, the next non-conflicting one takes port B.
    // A conflict is the same address with at least one write; read-read sharing is allowed.
    always_comb begin
        int idx;
        idx     = 0;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        if (rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % N_REQ;
                if (req_valid[idx]) begin
                    if (!a_found) begin
                        a_found = 1'b1;
                        a_idx   = PTR_W'(idx);
                    end else if (!b_found &&
                                 !((req_addr[idx*ADDR_W +: ADDR_W] ==
                                    req_addr[int'(a_idx)*ADDR_W +: ADDR_W]) &&
                                   (req_wen[idx] || req_wen[a_idx]))) begin
                        b_found = 1'b1;
                        b_idx   = PTR_W'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        addr_a    = '0;
        addr_b    = '0;
        d_a       = '0;
        d_b       = '0;
        wen_a     = 1'b0;
        wen_b     = 1'b0;
        if (a_found) begin
            req_ready[a_idx] = 1'b1;
            addr_a           = req_addr[int'(a_idx)*ADDR_W +: ADDR_W];
            d_a              = req_d[int'(a_idx)*DATA_W +: DATA_W];
            wen_a            = req_wen[a_idx];
        end
        if (b_found) begin
            req_ready[b_idx] = 1'b1;
            addr_b           = req_addr[int'(b_idx)*ADDR_W +: ADDR_W];
            d_b              = req_d[int'(b_idx)*DATA_W +: DATA_W];
            wen_b            = req_wen[b_idx];
        end
    end

    // Port B is always later in scan order than port A, so it is the last grant when present.
    always_comb begin
        last_idx = b_found ? b_idx : a_idx;
        next_ptr = PTR_W'((int'(last_idx) + 1) % N_REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            pend_a_valid <= 1'b0;
            pend_b_valid <= 1'b0;
            pend_a_idx   <= '0;
            pend_b_idx   <= '0;
        end else begin
            if (a_found) begin
                rr_ptr <= next_ptr;
            end
            pend_a_valid <= a_found && !wen_a;
            pend_b_valid <= b_found && !wen_b;
            pend_a_idx   <= a_idx;
            pend_b_idx   <= b_idx;
        end
    end

    // Both pending entries never name the same requester, so the two writes below never overlap.
    always_comb begin
        rsp_valid = '0;
        rsp_q     = '0;
        if (pend_a_valid) begin
            rsp_valid[pend_a_idx]                      = 1'b1;
            rsp_q[int'(pend_a_idx)*DATA_W +: DATA_W]   = q_a;
        end
        if (pend_b_valid) begin
            rsp_valid[pend_b_idx]                      = 1'b1;
            rsp_q[int'(pend_b_idx)*DATA_W +: DATA_W]   = q_b;
        end
    end

endmodule
